id_ex_stage: RTL and testbench
==============================

// Module: id_ex_stage
// PURPOSE
//  Decode/issue stage between IF/ID and EX. Decodes the incoming instruction and drives the register_file read addresses.
//  Forwards write-back data that collides with a same-cycle read, generates immediates and detects load-use hazards.
//  Registers the result into the ID/EX pipeline register consumed by the ALU stage.
// PARAMETERS
//  XLEN    32   datapath width
//  REG_AW  5    register address width
// PORTS
//  clock        in   1       rising-edge clock
//  reset_n      in   1       asynchronous active-low reset
//  id_valid     in   1       IF/ID holds a live instruction
//  id_instr     in   32      instruction word
//  id_pc        in   XLEN    instruction PC
//  read1/read2  out  REG_AW  register_file read addresses (rs1/rs2)
//  data1/data2  in   XLEN    register_file combinational read data
//  wb_en        in   1       write-back enable (same signal as register_file inEn)
//  wb_reg       in   REG_AW  write-back destination
//  wb_data      in   XLEN    write-back data
//  flush        in   1       kill the ID instruction (taken branch/jump)
//  stall_id     out  1       hold PC and IF/ID this cycle
//  ex_valid     out  1       ID/EX holds a live instruction
//  ex_pc        out  XLEN    registered PC
//  ex_rs1_val   out  XLEN    operand 1, post-bypass
//  ex_rs2_val   out  XLEN    operand 2, post-bypass
//  ex_imm       out  XLEN    sign-extended immediate
//  ex_rs1/ex_rs2/ex_rd  out  REG_AW  register indices
//  ex_opcode    out  7       instr[6:0]
//  ex_funct3    out  3       instr[14:12]
//  ex_funct7b5  out  1       instr[30]
//  ex_memread   out  1       instruction is a LOAD
//  ex_regwrite  out  1       instruction writes a register with rd != 0
// BEHAVIOUR
//  - Clock is `clock`. Reset is `reset_n`: asynchronous, active-low; when low every ex_* output is 0 immediately.
//  - read1 = id_instr[19:15] and read2 = id_instr[24:20], combinational and independent of id_valid.
//  - Bypass (combinational): if wb_en && wb_reg != 0 && wb_reg == rsN, the operand is wb_data; otherwise dataN. x0 reads 0.
//  - Immediate formats, sign bit instr[31]:
//    - I: LOAD / OP-IMM / JALR
//    - S: STORE
//    - B: BRANCH, bit0 = 0
//    - U: LUI / AUIPC, low 12 bits = 0
//    - J: JAL, bit0 = 0
//    - All other opcodes: 0.
//  - regwrite = opcode in {LUI, AUIPC, JAL, JALR, LOAD, OP-IMM, OP} && rd != 0. memread = (opcode == LOAD).
//  - Source use:
//    - rs1 is used by every opcode except LUI, AUIPC and JAL.
//    - rs2 is used only by OP, STORE and BRANCH.
//  - Hazard: stall_id = id_valid && !flush && ex_valid && ex_memread && ex_rd != 0 && ex_rd matches a used source.
//  - ID/EX update at posedge, in priority order:
//    - reset
//    - flush: ex_valid <= 0
//    - stall_id: bubble, ex_valid <= 0, ex_regwrite <= 0, ex_memread <= 0
//    - otherwise: load all fields, ex_valid <= id_valid
//  - A bubble clears ex_regwrite and ex_memread; other fields are don't-care.
//  - Latency: one cycle from ID to EX. A stall lasts exactly one cycle, because the bubble clears ex_memread.
//  - Unknown opcode: passes with ex_valid = 1, regwrite = 0, memread = 0, imm = 0. Trap handling belongs downstream.
//  - Reset deasserted mid-stream: the first post-reset edge loads normally; no stale stall.
// TESTING
//  1. Drive reset_n=0 while ex_valid=1 -> all ex_* outputs 0 before the next clock edge.
//  2. ADDI x5,x0,-1 (0xFFF00293) -> read1=0; next cycle ex_imm=0xFFFFFFFF, ex_rd=5, ex_regwrite=1, ex_rs1_val=0.
//  3. ADD x1,x3,x3, wb_en=1, wb_reg=3, wb_data=0xDEADBEEF, data1=data2=0x11 -> both operands 0xDEADBEEF.
//     Same stimulus with wb_reg=0 -> both operands 0x11.
//  4. LW x7,0(x2) then ADD x8,x7,x1 -> stall_id=1 for 1 cycle, one bubble, then ADD issued.
//     LW x7 then LUI x7 -> no stall.
//  5. Load-use condition present together with flush=1 -> stall_id=0, ex_valid=0 next cycle.
//  6. BEQ x0,x0,-4 (0xFE000EE3) -> ex_imm=0xFFFFFFFC, ex_regwrite=0, ex_memread=0.

Source files
------------

// File: rtl/id_ex_stage_if.sv
// Decode-stage bus: IF/ID inputs, register-file read port, write-back bypass and ID/EX outputs.
interface id_ex_stage_if #(
    parameter int unsigned XLEN   = 32,
    parameter int unsigned REG_AW = 5
);
    logic              id_valid;
    logic [31:0]       id_instr;
    logic [XLEN-1:0]   id_pc;
    logic [REG_AW-1:0] read1;
    logic [REG_AW-1:0] read2;
    logic [XLEN-1:0]   data1;
    logic [XLEN-1:0]   data2;
    logic              wb_en;
    logic [REG_AW-1:0] wb_reg;
    logic [XLEN-1:0]   wb_data;
    logic              flush;
    logic              stall_id;
    logic              ex_valid;
    logic [XLEN-1:0]   ex_pc;
    logic [XLEN-1:0]   ex_rs1_val;
    logic [XLEN-1:0]   ex_rs2_val;
    logic [XLEN-1:0]   ex_imm;
    logic [REG_AW-1:0] ex_rs1;
    logic [REG_AW-1:0] ex_rs2;
    logic [REG_AW-1:0] ex_rd;
    logic [6:0]        ex_opcode;
    logic [2:0]        ex_funct3;
    logic              ex_funct7b5;
    logic              ex_memread;
    logic              ex_regwrite;

    // Upstream/pipeline side driving the stage
    modport master (
        output id_valid, id_instr, id_pc, data1, data2, wb_en, wb_reg, wb_data, flush,
        input  read1, read2, stall_id, ex_valid, ex_pc, ex_rs1_val, ex_rs2_val, ex_imm,
               ex_rs1, ex_rs2, ex_rd, ex_opcode, ex_funct3, ex_funct7b5, ex_memread, ex_regwrite
    );

    // The decode stage itself
    modport slave (
        input  id_valid, id_instr, id_pc, data1, data2, wb_en, wb_reg, wb_data, flush,
        output read1, read2, stall_id, ex_valid, ex_pc, ex_rs1_val, ex_rs2_val, ex_imm,
               ex_rs1, ex_rs2, ex_rd, ex_opcode, ex_funct3, ex_funct7b5, ex_memread, ex_regwrite
    );
endinterface

// File: rtl/id_ex_stage.sv
// Decode/issue stage: decode, register read with write-back bypass, immediate generation,
// load-use hazard detection and the ID/EX pipeline register.
module id_ex_stage #(
    parameter int unsigned XLEN   = 32,
    parameter int unsigned REG_AW = 5
) (
    input logic         clock,
    input logic         reset_n,
    id_ex_stage_if.slave bus
);
    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
    localparam logic [6:0] OPC_OP     = 7'b0110011;

    logic [31:0]       instr;
    logic [6:0]        opcode_c;
    logic [REG_AW-1:0] rs1_c;
    logic [REG_AW-1:0] rs2_c;
    logic [REG_AW-1:0] rd_c;
    logic [XLEN-1:0]   imm_c;
    logic [XLEN-1:0]   rs1_val_c;
    logic [XLEN-1:0]   rs2_val_c;
    logic              use_rs1_c;
    logic              use_rs2_c;
    logic              regwrite_c;
    logic              memread_c;
    logic              stall_c;

    logic              ex_valid;
    logic [XLEN-1:0]   ex_pc;
    logic [XLEN-1:0]   ex_rs1_val;
    logic [XLEN-1:0]   ex_rs2_val;
    logic [XLEN-1:0]   ex_imm;
    logic [REG_AW-1:0] ex_rs1;
    logic [REG_AW-1:0] ex_rs2;
    logic [REG_AW-1:0] ex_rd;
    logic [6:0]        ex_opcode;
    logic [2:0]        ex_funct3;
    logic              ex_funct7b5;
    logic              ex_memread;
    logic              ex_regwrite;

    assign instr    = bus.id_instr;
    assign opcode_c = instr[6:0];
    assign rs1_c    = REG_AW'(instr[19:15]);
    assign rs2_c    = REG_AW'(instr[24:20]);
    assign rd_c     = REG_AW'(instr[11:7]);

    // Register-file read addresses come straight from the instruction word
    assign bus.read1 = rs1_c;
    assign bus.read2 = rs2_c;

    // Immediate generation; every format sign-extends from instr[31]
    always_comb begin
        imm_c = '0;
        case (opcode_c)
            OPC_LOAD, OPC_OPIMM, OPC_JALR:
                imm_c = XLEN'($signed(instr[31:20]));
            OPC_STORE:
                imm_c = XLEN'($signed({instr[31:25], instr[11:7]}));
            OPC_BRANCH:
                imm_c = XLEN'($signed({instr[31], instr[7], instr[30:25], instr[11:8], 1'b0}));
            OPC_LUI, OPC_AUIPC:
                imm_c = XLEN'($signed({instr[31:12], 12'b0}));
            OPC_JAL:
                imm_c = XLEN'($signed({instr[31], instr[19:12], instr[20], instr[30:21], 1'b0}));
            default:
                imm_c = '0;
        endcase
    end

    // Operand read with same-cycle write-back bypass; x0 is hardwired to zero
    always_comb begin
        rs1_val_c = bus.data1;
        rs2_val_c = bus.data2;
        if (rs1_c == '0) begin
            rs1_val_c = '0;
        end else if (bus.wb_en && (bus.wb_reg == rs1_c)) begin
            rs1_val_c = bus.wb_data;
        end
        if (rs2_c == '0) begin
            rs2_val_c = '0;
        end else if (bus.wb_en && (bus.wb_reg == rs2_c)) begin
            rs2_val_c = bus.wb_data;
        end
    end

    // Control decode and load-use hazard detection
    always_comb begin
        use_rs1_c  = !((opcode_c == OPC_LUI) || (opcode_c == OPC_AUIPC) || (opcode_c == OPC_JAL));
        use_rs2_c  = (opcode_c == OPC_OP) || (opcode_c == OPC_STORE) || (opcode_c == OPC_BRANCH);
        memread_c  = (opcode_c == OPC_LOAD);
        regwrite_c = 1'b0;
        case (opcode_c)
            OPC_LUI, OPC_AUIPC, OPC_JAL, OPC_JALR, OPC_LOAD, OPC_OPIMM, OPC_OP:
                regwrite_c = (rd_c != '0);
            default:
                regwrite_c = 1'b0;
        endcase
        stall_c = bus.id_valid && !bus.flush && ex_valid && ex_memread && (ex_rd != '0) &&
                  ((use_rs1_c && (ex_rd == rs1_c)) || (use_rs2_c && (ex_rd == rs2_c)));
    end

    assign bus.stall_id = stall_c;

    // ID/EX pipeline register: flush beats stall, stall inserts a bubble
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            ex_valid    <= 1'b0;
            ex_pc       <= '0;
            ex_rs1_val  <= '0;
            ex_rs2_val  <= '0;
            ex_imm      <= '0;
            ex_rs1      <= '0;
            ex_rs2      <= '0;
            ex_rd       <= '0;
            ex_opcode   <= '0;
            ex_funct3   <= '0;
            ex_funct7b5 <= 1'b0;
            ex_memread  <= 1'b0;
            ex_regwrite <= 1'b0;
        end else if (bus.flush) begin
            ex_valid <= 1'b0;
        end else if (stall_c) begin
            ex_valid    <= 1'b0;
            ex_regwrite <= 1'b0;
            ex_memread  <= 1'b0;
        end else begin
            ex_valid    <= bus.id_valid;
            ex_pc       <= bus.id_pc;
            ex_rs1_val  <= rs1_val_c;
            ex_rs2_val  <= rs2_val_c;
            ex_imm      <= imm_c;
            ex_rs1      <= rs1_c;
            ex_rs2      <= rs2_c;
            ex_rd       <= rd_c;
            ex_opcode   <= opcode_c;
            ex_funct3   <= instr[14:12];
            ex_funct7b5 <= instr[30];
            ex_memread  <= memread_c;
            ex_regwrite <= regwrite_c;
        end
    end

    assign bus.ex_valid    = ex_valid;
    assign bus.ex_pc       = ex_pc;
    assign bus.ex_rs1_val  = ex_rs1_val;
    assign bus.ex_rs2_val  = ex_rs2_val;
    assign bus.ex_imm      = ex_imm;
    assign bus.ex_rs1      = ex_rs1;
    assign bus.ex_rs2      = ex_rs2;
    assign bus.ex_rd       = ex_rd;
    assign bus.ex_opcode   = ex_opcode;
    assign bus.ex_funct3   = ex_funct3;
    assign bus.ex_funct7b5 = ex_funct7b5;
    assign bus.ex_memread  = ex_memread;
    assign bus.ex_regwrite = ex_regwrite;
endmodule

// File: tb/tb_id_ex_stage.sv
// Self-checking bench for id_ex_stage: scoreboard of expected ID/EX contents plus directed cases.
module tb_id_ex_stage;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_OPIMM  = 7'b0010011;
    localparam logic [6:0] OP_OP     = 7'b0110011;

    localparam int K_FULL   = 0;
    localparam int K_BUBBLE = 1;
    localparam int K_FLUSH  = 2;

    typedef struct {
        int          kind;
        logic        valid;
        logic [31:0] pc;
        logic [31:0] v1;
        logic [31:0] v2;
        logic [31:0] imm;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic [4:0]  rd;
        logic [6:0]  op;
        logic [2:0]  f3;
        logic        f7;
        logic        mr;
        logic        rw;
    } exp_t;

    logic clock = 1'b0;
    logic reset_n;

    id_ex_stage_if #(.XLEN(32), .REG_AW(5)) bus ();

    id_ex_stage #(.XLEN(32), .REG_AW(5)) dut (
        .clock   (clock),
        .reset_n (reset_n),
        .bus     (bus)
    );

    always #5 clock = ~clock;

    exp_t        sb[$];
    int          n_checks = 0;
    int          n_errors = 0;
    logic [31:0] pc       = 32'h0000_1000;
    logic        m_valid  = 1'b0;
    logic        m_memread = 1'b0;
    logic [4:0]  m_rd     = 5'd0;
    logic        last_stall;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] enc_r(input logic [6:0] f7, input logic [4:0] rs2,
                                          input logic [4:0] rs1, input logic [2:0] f3,
                                          input logic [4:0] rd, input logic [6:0] op);
        return {f7, rs2, rs1, f3, rd, op};
    endfunction

    function automatic logic [31:0] enc_i(input logic [11:0] imm, input logic [4:0] rs1,
                                          input logic [2:0] f3, input logic [4:0] rd,
                                          input logic [6:0] op);
        return {imm, rs1, f3, rd, op};
    endfunction

    function automatic logic [31:0] enc_u(input logic [19:0] imm, input logic [4:0] rd,
                                          input logic [6:0] op);
        return {imm, rd, op};
    endfunction

    function automatic logic [31:0] imm_of(input logic [31:0] i);
        case (i[6:0])
            OP_LOAD, OP_OPIMM, OP_JALR: return {{20{i[31]}}, i[31:20]};
            OP_STORE:                   return {{20{i[31]}}, i[31:25], i[11:7]};
            OP_BRANCH:                  return {{20{i[31]}}, i[7], i[30:25], i[11:8], 1'b0};
            OP_LUI, OP_AUIPC:           return {i[31:12], 12'h000};
            OP_JAL:                     return {{12{i[31]}}, i[19:12], i[20], i[30:21], 1'b0};
            default:                    return 32'h0;
        endcase
    endfunction

    // One ID cycle: drive, predict, check combinational outputs, then check the registered result
    task automatic step(input logic v, input logic [31:0] ins, input logic [31:0] d1,
                        input logic [31:0] d2, input logic we, input logic [4:0] wr,
                        input logic [31:0] wd, input logic fl);
        exp_t        e;
        exp_t        g;
        logic [6:0]  op;
        logic [4:0]  s1;
        logic [4:0]  s2;
        logic [4:0]  rd;
        logic        u1;
        logic        u2;
        logic        hz;
        op = ins[6:0];
        s1 = ins[19:15];
        s2 = ins[24:20];
        rd = ins[11:7];
        bus.id_valid = v;
        bus.id_instr = ins;
        bus.id_pc    = pc;
        bus.data1    = d1;
        bus.data2    = d2;
        bus.wb_en    = we;
        bus.wb_reg   = wr;
        bus.wb_data  = wd;
        bus.flush    = fl;

        u1 = !(op == OP_LUI || op == OP_AUIPC || op == OP_JAL);
        u2 = (op == OP_OP || op == OP_STORE || op == OP_BRANCH);
        hz = v && !fl && m_valid && m_memread && (m_rd != 5'd0) &&
             ((u1 && m_rd == s1) || (u2 && m_rd == s2));

        e       = '{default: '0};
        e.valid = 1'b0;
        if (fl) begin
            e.kind  = K_FLUSH;
            m_valid = 1'b0;
        end else if (hz) begin
            e.kind    = K_BUBBLE;
            m_valid   = 1'b0;
            m_memread = 1'b0;
        end else begin
            e.kind  = K_FULL;
            e.valid = v;
            e.pc    = pc;
            e.v1    = (s1 == 5'd0) ? 32'h0 : ((we && wr == s1) ? wd : d1);
            e.v2    = (s2 == 5'd0) ? 32'h0 : ((we && wr == s2) ? wd : d2);
            e.imm   = imm_of(ins);
            e.rs1   = s1;
            e.rs2   = s2;
            e.rd    = rd;
            e.op    = op;
            e.f3    = ins[14:12];
            e.f7    = ins[30];
            e.mr    = (op == OP_LOAD);
            e.rw    = (rd != 5'd0) && (op == OP_LUI || op == OP_AUIPC || op == OP_JAL ||
                      op == OP_JALR || op == OP_LOAD || op == OP_OPIMM || op == OP_OP);
            m_valid   = v;
            m_memread = e.mr;
            m_rd      = rd;
        end

        @(negedge clock);
        chk("read1", 32'(bus.read1), 32'(s1));
        chk("read2", 32'(bus.read2), 32'(s2));
        chk("stall_id", 32'(bus.stall_id), 32'(hz));
        last_stall = bus.stall_id;
        sb.push_back(e);

        @(posedge clock);
        #1;
        g = sb.pop_front();
        chk("ex_valid", 32'(bus.ex_valid), 32'(g.valid));
        if (g.kind == K_BUBBLE) begin
            chk("bubble_regwrite", 32'(bus.ex_regwrite), 32'h0);
            chk("bubble_memread", 32'(bus.ex_memread), 32'h0);
        end else if (g.kind == K_FULL) begin
            chk("ex_pc", bus.ex_pc, g.pc);
            chk("ex_rs1_val", bus.ex_rs1_val, g.v1);
            chk("ex_rs2_val", bus.ex_rs2_val, g.v2);
            chk("ex_imm", bus.ex_imm, g.imm);
            chk("ex_rs1", 32'(bus.ex_rs1), 32'(g.rs1));
            chk("ex_rs2", 32'(bus.ex_rs2), 32'(g.rs2));
            chk("ex_rd", 32'(bus.ex_rd), 32'(g.rd));
            chk("ex_opcode", 32'(bus.ex_opcode), 32'(g.op));
            chk("ex_funct3", 32'(bus.ex_funct3), 32'(g.f3));
            chk("ex_funct7b5", 32'(bus.ex_funct7b5), 32'(g.f7));
            chk("ex_memread", 32'(bus.ex_memread), 32'(g.mr));
            chk("ex_regwrite", 32'(bus.ex_regwrite), 32'(g.rw));
        end
        pc = pc + 32'd4;
    endtask

    task automatic check_all_zero(input string tag);
        chk({tag, "_valid"}, 32'(bus.ex_valid), 32'h0);
        chk({tag, "_pc"}, bus.ex_pc, 32'h0);
        chk({tag, "_rs1_val"}, bus.ex_rs1_val, 32'h0);
        chk({tag, "_rs2_val"}, bus.ex_rs2_val, 32'h0);
        chk({tag, "_imm"}, bus.ex_imm, 32'h0);
        chk({tag, "_rs1"}, 32'(bus.ex_rs1), 32'h0);
        chk({tag, "_rs2"}, 32'(bus.ex_rs2), 32'h0);
        chk({tag, "_rd"}, 32'(bus.ex_rd), 32'h0);
        chk({tag, "_opcode"}, 32'(bus.ex_opcode), 32'h0);
        chk({tag, "_funct3"}, 32'(bus.ex_funct3), 32'h0);
        chk({tag, "_funct7b5"}, 32'(bus.ex_funct7b5), 32'h0);
        chk({tag, "_memread"}, 32'(bus.ex_memread), 32'h0);
        chk({tag, "_regwrite"}, 32'(bus.ex_regwrite), 32'h0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [6:0]  ops [10];
        logic [31:0] r;
        logic [31:0] add_bad;
        ops = '{OP_LUI, OP_AUIPC, OP_JAL, OP_JALR, OP_BRANCH, OP_LOAD, OP_STORE,
                OP_OPIMM, OP_OP, 7'b1111111};

        reset_n      = 1'b0;
        bus.id_valid = 1'b0;
        bus.id_instr = 32'h0;
        bus.id_pc    = 32'h0;
        bus.data1    = 32'h0;
        bus.data2    = 32'h0;
        bus.wb_en    = 1'b0;
        bus.wb_reg   = 5'd0;
        bus.wb_data  = 32'h0;
        bus.flush    = 1'b0;
        repeat (2) @(posedge clock);
        #1;
        check_all_zero("reset");
        reset_n = 1'b1;

        // ADDI x5,x0,-1
        step(1'b1, 32'hFFF00293, 32'h1234_5678, 32'h0, 1'b0, 5'd0, 32'h0, 1'b0);
        chk("addi_imm", bus.ex_imm, 32'hFFFF_FFFF);
        chk("addi_rd", 32'(bus.ex_rd), 32'd5);
        chk("addi_regwrite", 32'(bus.ex_regwrite), 32'd1);
        chk("addi_rs1_val", bus.ex_rs1_val, 32'h0);

        // Asynchronous reset with a live instruction in ID/EX
        #1 reset_n = 1'b0;
        #1 check_all_zero("async_rst");
        #1 reset_n = 1'b1;
        m_valid   = 1'b0;
        m_memread = 1'b0;
        m_rd      = 5'd0;

        // ADD x1,x3,x3 with bypass, then with wb_reg=x0
        step(1'b1, enc_r(7'd0, 5'd3, 5'd3, 3'd0, 5'd1, OP_OP), 32'h11, 32'h11,
             1'b1, 5'd3, 32'hDEAD_BEEF, 1'b0);
        chk("bypass_rs1", bus.ex_rs1_val, 32'hDEAD_BEEF);
        chk("bypass_rs2", bus.ex_rs2_val, 32'hDEAD_BEEF);
        step(1'b1, enc_r(7'd0, 5'd3, 5'd3, 3'd0, 5'd1, OP_OP), 32'h11, 32'h11,
             1'b1, 5'd0, 32'hDEAD_BEEF, 1'b0);
        chk("nobypass_rs1", bus.ex_rs1_val, 32'h11);
        chk("nobypass_rs2", bus.ex_rs2_val, 32'h11);

        // LW x7,0(x2) then ADD x8,x7,x1: one stall cycle, one bubble, then issue
        add_bad = enc_r(7'd0, 5'd1, 5'd7, 3'd0, 5'd8, OP_OP);
        step(1'b1, enc_i(12'd0, 5'd2, 3'b010, 5'd7, OP_LOAD), 32'h100, 32'h0, 1'b0, 5'd0, 32'h0, 1'b0);
        chk("lw_memread", 32'(bus.ex_memread), 32'd1);
        step(1'b1, add_bad, 32'h5, 32'h6, 1'b0, 5'd0, 32'h0, 1'b0);
        chk("lu_stall_first", 32'(last_stall), 32'd1);
        chk("lu_bubble_valid", 32'(bus.ex_valid), 32'd0);
        pc = pc - 32'd4;
        step(1'b1, add_bad, 32'h5, 32'h6, 1'b0, 5'd0, 32'h0, 1'b0);
        chk("lu_stall_second", 32'(last_stall), 32'd0);
        chk("lu_issue_valid", 32'(bus.ex_valid), 32'd1);
        chk("lu_issue_rd", 32'(bus.ex_rd), 32'd8);

        // LW x7 then LUI x7: no source use, no stall
        step(1'b1, enc_i(12'd4, 5'd2, 3'b010, 5'd7, OP_LOAD), 32'h100, 32'h0, 1'b0, 5'd0, 32'h0, 1'b0);
        step(1'b1, enc_u(20'hABCDE, 5'd7, OP_LUI), 32'h0, 32'h0, 1'b0, 5'd0, 32'h0, 1'b0);
        chk("lui_no_stall", 32'(last_stall), 32'd0);
        chk("lui_imm", bus.ex_imm, 32'hABCD_E000);

        // Load-use pattern with flush: flush wins, no stall
        step(1'b1, enc_i(12'd0, 5'd2, 3'b010, 5'd7, OP_LOAD), 32'h100, 32'h0, 1'b0, 5'd0, 32'h0, 1'b0);
        step(1'b1, add_bad, 32'h5, 32'h6, 1'b0, 5'd0, 32'h0, 1'b1);
        chk("flush_no_stall", 32'(last_stall), 32'd0);
        chk("flush_valid", 32'(bus.ex_valid), 32'd0);

        // BEQ x0,x0,-4
        step(1'b1, 32'hFE000EE3, 32'h0, 32'h0, 1'b0, 5'd0, 32'h0, 1'b0);
        chk("beq_imm", bus.ex_imm, 32'hFFFF_FFFC);
        chk("beq_regwrite", 32'(bus.ex_regwrite), 32'd0);
        chk("beq_memread", 32'(bus.ex_memread), 32'd0);

        // Unknown opcode passes through as valid with no side effects
        step(1'b1, 32'hFFFF_FFFF, 32'h1, 32'h2, 1'b0, 5'd0, 32'h0, 1'b0);
        chk("unk_valid", 32'(bus.ex_valid), 32'd1);
        chk("unk_regwrite", 32'(bus.ex_regwrite), 32'd0);
        chk("unk_imm", bus.ex_imm, 32'h0);

        // Random mix on a small register set to provoke hazards and bypasses
        for (int k = 0; k < 60; k++) begin
            r       = $urandom();
            r[6:0]  = ops[$urandom_range(0, 9)];
            r[11:7] = 5'($urandom_range(0, 3));
            r[19:15] = 5'($urandom_range(0, 3));
            r[24:20] = 5'($urandom_range(0, 3));
            step(($urandom_range(0, 7) != 0), r, $urandom(), $urandom(),
                 1'($urandom_range(0, 1)), 5'($urandom_range(0, 3)), $urandom(),
                 ($urandom_range(0, 7) == 0));
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end
endmodule
